// File: rtl/iob_fp_mul_arb.sv
// Round-robin arbiter that shares one pipelined FP multiplier among N_REQ requesters.
// Each issued operation carries its requester index through a tag pipe that mirrors the multiplier latency.
module iob_fp_mul_arb #(
   parameter int DATA_W  = 32,
   parameter int EXP_W   = 8,
   parameter int N_REQ   = 4,
   parameter int MUL_LAT = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    en_i,
   input  logic [N_REQ-1:0]        req_valid_i,
   output logic [N_REQ-1:0]        req_ready_o,
   input  logic [N_REQ*DATA_W-1:0] req_op_a_i,
   input  logic [N_REQ*DATA_W-1:0] req_op_b_i,
   output logic [N_REQ-1:0]        resp_valid_o,
   output logic [DATA_W-1:0]       resp_res_o,
   output logic                    mul_start_o,
   output logic [DATA_W-1:0]       mul_op_a_o,
   output logic [DATA_W-1:0]       mul_op_b_o,
   input  logic                    mul_done_i,
   input  logic [DATA_W-1:0]       mul_res_i,
   output logic                    busy_o,
   output logic                    error_o
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   if (EXP_W >= DATA_W || N_REQ < 1 || MUL_LAT < 1) begin : g_param_check
      $error("iob_fp_mul_arb: invalid parameter combination");
   end

   logic [DATA_W-1:0] op_a [N_REQ];
   logic [DATA_W-1:0] op_b [N_REQ];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign op_a[gi] = req_op_a_i[gi*DATA_W +: DATA_W];
      assign op_b[gi] = req_op_b_i[gi*DATA_W +: DATA_W];
   end

   logic [IDX_W-1:0]  ptr_reg, ptr_next;
   logic [N_REQ-1:0]  grant;
   logic [IDX_W-1:0]  grant_idx;
   logic              grant_found;
   logic              accept;
   int                scan_idx;

   // Scan from the pointer and wrap; the first valid requester wins.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_found = 1'b0;
      scan_idx    = 0;
      for (int i = 0; i < N_REQ; i++) begin
         scan_idx = int'(ptr_reg) + i;
         if (scan_idx >= N_REQ) begin
            scan_idx = scan_idx - N_REQ;
         end
         if (en_i && !grant_found && req_valid_i[scan_idx]) begin
            grant_found     = 1'b1;
            grant[scan_idx] = 1'b1;
            grant_idx       = IDX_W'(scan_idx);
         end
      end
   end

   assign accept      = grant_found;
   assign req_ready_o = grant;

   always_comb begin
      ptr_next = ptr_reg;
      if (accept) begin
         ptr_next = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
   end

   logic              issue_valid_reg;
   logic [IDX_W-1:0]  issue_idx_reg;
   logic [DATA_W-1:0] op_a_reg, op_b_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_reg         <= '0;
         issue_valid_reg <= 1'b0;
         issue_idx_reg   <= '0;
         op_a_reg        <= '0;
         op_b_reg        <= '0;
      end else begin
         ptr_reg         <= ptr_next;
         issue_valid_reg <= accept;
         if (accept) begin
            issue_idx_reg <= grant_idx;
            op_a_reg      <= op_a[grant_idx];
            op_b_reg      <= op_b[grant_idx];
         end
      end
   end

   assign mul_start_o = issue_valid_reg;
   assign mul_op_a_o  = op_a_reg;
   assign mul_op_b_o  = op_b_reg;

   // Stage 0 follows the issue register, so the last stage lines up with mul_done_i.
   logic [MUL_LAT-1:0] tag_valid_reg;
   logic [IDX_W-1:0]   tag_idx_reg [MUL_LAT];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tag_valid_reg[0] <= 1'b0;
         tag_idx_reg[0]   <= '0;
      end else begin
         tag_valid_reg[0] <= issue_valid_reg;
         tag_idx_reg[0]   <= issue_idx_reg;
      end
   end

   for (genvar gi = 1; gi < MUL_LAT; gi++) begin : g_tag_pipe
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            tag_valid_reg[gi] <= 1'b0;
            tag_idx_reg[gi]   <= '0;
         end else begin
            tag_valid_reg[gi] <= tag_valid_reg[gi-1];
            tag_idx_reg[gi]   <= tag_idx_reg[gi-1];
         end
      end
   end

   logic              head_valid;
   logic [IDX_W-1:0]  head_idx;
   logic              resp_fire;
   logic [N_REQ-1:0]  resp_onehot;
   logic [N_REQ-1:0]  resp_valid_reg;
   logic [DATA_W-1:0] resp_res_reg;
   logic              error_reg;

   assign head_valid = tag_valid_reg[MUL_LAT-1];
   assign head_idx   = tag_idx_reg[MUL_LAT-1];
   assign resp_fire  = head_valid & mul_done_i;

   always_comb begin
      resp_onehot = '0;
      if (resp_fire) begin
         resp_onehot[head_idx] = 1'b1;
      end
   end

   // Any disagreement between the tag head and mul_done_i means the multiplier latency is off.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         resp_valid_reg <= '0;
         resp_res_reg   <= '0;
         error_reg      <= 1'b0;
      end else begin
         resp_valid_reg <= resp_onehot;
         if (resp_fire) begin
            resp_res_reg <= mul_res_i;
         end
         if (head_valid != mul_done_i) begin
            error_reg <= 1'b1;
         end
      end
   end

   assign resp_valid_o = resp_valid_reg;
   assign resp_res_o   = resp_res_reg;
   assign error_o      = error_reg;
   assign busy_o       = issue_valid_reg | (|tag_valid_reg) | (|resp_valid_reg);

endmodule

// File: tb/tb_iob_fp_mul_arb.sv
// Directed bench for iob_fp_mul_arb with a behavioural multiplier of selectable latency.
`timescale 1ns/1ps
module tb_iob_fp_mul_arb;
   localparam int DATA_W = 32;
   localparam int N_REQ  = 4;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    en;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ*DATA_W-1:0] req_op_a;
   logic [N_REQ*DATA_W-1:0] req_op_b;
   logic [N_REQ-1:0]        resp_valid;
   logic [DATA_W-1:0]       resp_res;
   logic                    mul_start;
   logic [DATA_W-1:0]       mul_op_a, mul_op_b;
   logic                    mul_done;
   logic [DATA_W-1:0]       mul_res;
   logic                    busy, error;

   int n_checks = 0;
   int n_errors = 0;
   int lat = 4;
   int resp_cnt = 0;

   always #5 clk = ~clk;

   iob_fp_mul_arb #(.DATA_W(DATA_W), .EXP_W(8), .N_REQ(N_REQ), .MUL_LAT(4)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_op_a_i(req_op_a), .req_op_b_i(req_op_b),
      .resp_valid_o(resp_valid), .resp_res_o(resp_res),
      .mul_start_o(mul_start), .mul_op_a_o(mul_op_a), .mul_op_b_o(mul_op_b),
      .mul_done_i(mul_done), .mul_res_i(mul_res),
      .busy_o(busy), .error_o(error)
   );

   // Known products for the directed vectors; anything else gets a recognisable mix.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
      if (a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40100000;
      if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h3F800000;
      return a ^ b;
   endfunction

   logic [7:0]        mdl_v;
   logic [DATA_W-1:0] mdl_r [8];

   always @(posedge clk) begin
      if (rst) begin
         mdl_v <= '0;
      end else begin
         mdl_v <= {mdl_v[6:0], mul_start};
      end
      mdl_r[0] <= fmul(mul_op_a, mul_op_b);
      for (int j = 1; j < 8; j++) mdl_r[j] <= mdl_r[j-1];
   end

   assign mul_done = mdl_v[lat-1];
   assign mul_res  = mdl_r[lat-1];

   always @(negedge clk) begin
      if (resp_valid != '0) resp_cnt <= resp_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic set_ops(input int k, input logic [31:0] a, input logic [31:0] b);
      req_op_a[k*DATA_W +: DATA_W] = a;
      req_op_b[k*DATA_W +: DATA_W] = b;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      req_valid = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " ready"}, 32'(req_ready), 32'h0);
      check({tag, " resp_valid"}, 32'(resp_valid), 32'h0);
      check({tag, " resp_res"}, resp_res, 32'h0);
      check({tag, " mul_start"}, 32'(mul_start), 32'h0);
      check({tag, " mul_op_a"}, mul_op_a, 32'h0);
      check({tag, " mul_op_b"}, mul_op_b, 32'h0);
      check({tag, " busy"}, 32'(busy), 32'h0);
      check({tag, " error"}, 32'(error), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g0, g2, cnt0;
      rst = 1'b1; en = 1'b1; req_valid = '0; req_op_a = '0; req_op_b = '0;
      repeat (3) step();
      check_reset_outputs("rst");
      rst = 1'b0;

      // Single op from requester 2
      set_ops(2, 32'h40000000, 32'h40400000);
      req_valid = 4'b0100; #1;
      check("single ready", 32'(req_ready), 32'h4);
      step(); req_valid = '0;
      check("single start", 32'(mul_start), 32'h1);
      check("single op_a", mul_op_a, 32'h40000000);
      check("single op_b", mul_op_b, 32'h40400000);
      check("single busy", 32'(busy), 32'h1);
      for (int c = 2; c <= 5; c++) begin
         step();
         check("single early resp", 32'(resp_valid), 32'h0);
      end
      step();
      check("single resp_valid", 32'(resp_valid), 32'h4);
      check("single resp_res", resp_res, 32'h40C00000);
      step();
      check("single pulse end", 32'(resp_valid), 32'h0);
      check("single res hold", resp_res, 32'h40C00000);
      check("single idle", 32'(busy), 32'h0);

      // Contention among 0, 1, 3 starting from pointer 0
      do_reset();
      set_ops(0, 32'h3FC00000, 32'h3FC00000);
      set_ops(1, 32'h40000000, 32'h40400000);
      set_ops(3, 32'h3F800000, 32'h3F800000);
      req_valid = 4'b1011; #1;
      check("cont grant0", 32'(req_ready), 32'h1);
      step(); req_valid = 4'b1010; #1;
      check("cont grant1", 32'(req_ready), 32'h2);
      check("cont start0 op_a", mul_op_a, 32'h3FC00000);
      step(); req_valid = 4'b1000; #1;
      check("cont grant3", 32'(req_ready), 32'h8);
      step(); req_valid = '0;
      step(); step();
      check("cont no resp t+5", 32'(resp_valid), 32'h0);
      step();
      check("cont resp0 valid", 32'(resp_valid), 32'h1);
      check("cont resp0 res", resp_res, 32'h40100000);
      step();
      check("cont resp1 valid", 32'(resp_valid), 32'h2);
      check("cont resp1 res", resp_res, 32'h40C00000);
      step();
      check("cont resp3 valid", 32'(resp_valid), 32'h8);
      check("cont resp3 res", resp_res, 32'h3F800000);

      // Fairness: 0 and 2 held valid for 8 cycles
      step();
      cnt0 = resp_cnt; g0 = 0; g2 = 0;
      set_ops(0, 32'h00000011, 32'h00000100);
      set_ops(2, 32'h00000022, 32'h00000200);
      req_valid = 4'b0101; #1;
      for (int i = 0; i < 8; i++) begin
         check("fair grant", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h4);
         if (req_ready[0]) g0++;
         if (req_ready[2]) g2++;
         if (i > 0) check("fair start", 32'(mul_start), 32'h1);
         step(); #1;
      end
      req_valid = '0;
      check("fair start last", 32'(mul_start), 32'h1);
      check("fair count 0", 32'(g0), 32'd4);
      check("fair count 2", 32'(g2), 32'd4);
      repeat (8) step();
      check("fair responses", 32'(resp_cnt - cnt0), 32'd8);
      check("fair idle", 32'(busy), 32'h0);
      check("fair error", 32'(error), 32'h0);

      // Enable gating, pointer at 3
      req_valid = 4'b1111; en = 1'b1; #1;
      check("en grant3", 32'(req_ready), 32'h8);
      step(); en = 1'b0; #1;
      check("en off ready", 32'(req_ready), 32'h0);
      check("en inflight start", 32'(mul_start), 32'h1);
      step();
      check("en off no start", 32'(mul_start), 32'h0);
      repeat (4) step();
      check("en inflight resp", 32'(resp_valid), 32'h8);
      check("en inflight res", resp_res, 32'h3F800000);
      step();
      check("en still blocked", 32'(req_ready), 32'h0);
      en = 1'b1; #1;
      check("en resume ptr", 32'(req_ready), 32'h1);
      step(); req_valid = '0;
      check("en resume start", 32'(mul_start), 32'h1);
      repeat (7) step();

      // Reset while three ops are in flight
      do_reset();
      req_valid = 4'b0111; #1;
      check("rstmid grant0", 32'(req_ready), 32'h1);
      step(); #1;
      check("rstmid grant1", 32'(req_ready), 32'h2);
      step(); #1;
      check("rstmid grant2", 32'(req_ready), 32'h4);
      step();
      req_valid = '0; rst = 1'b1;
      step();
      check_reset_outputs("rstmid");
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step();
         check("rstmid no resp", 32'(resp_valid), 32'h0);
      end
      req_valid = 4'b1010; #1;
      check("rstmid lowest", 32'(req_ready), 32'h2);
      step(); req_valid = '0;
      repeat (7) step();

      // Multiplier answering one cycle early
      lat = 3;
      do_reset();
      set_ops(2, 32'h40000000, 32'h40400000);
      req_valid = 4'b0100; #1;
      check("lat ready", 32'(req_ready), 32'h4);
      step(); req_valid = '0;
      step(); step(); step();
      check("lat error before", 32'(error), 32'h0);
      step();
      check("lat error set", 32'(error), 32'h1);
      check("lat no resp t+5", 32'(resp_valid), 32'h0);
      step();
      check("lat no resp t+6", 32'(resp_valid), 32'h0);
      step(); step();
      check("lat error sticky", 32'(error), 32'h1);
      check("lat res untouched", resp_res, 32'h0);
      lat = 4;
      do_reset();
      check("lat error cleared", 32'(error), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/iob_fp_mul_arb.md
Name: iob_fp_mul_arb

Overview:
Round-robin arbiter that shares one pipelined FP multiplier (iob_fp_mul interface: start/done, op_a/op_b, res) among N_REQ requesters. It accepts at most one request per cycle, issues it to the multiplier, and tags each in-flight operation with its requester index. It returns each result to the originating requester as a one-cycle pulse. It sits between the accelerator's compute units and a single multiplier instance.

Parameters:
DATA_W, 32, operand/result width
EXP_W, 8, exponent width (pass-through, informational)
N_REQ, 4, number of requesters (>=1)
MUL_LAT, 4, fixed multiplier latency: mul_start_o to mul_done_i, in cycles (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
en_i  in  1  grant enable; low blocks new grants
req_valid_i  in  N_REQ  per-requester request valid
req_ready_o  out  N_REQ  one-hot grant, combinational
req_op_a_i  in  N_REQ*DATA_W  operand A, requester k at [k*DATA_W +: DATA_W]
req_op_b_i  in  N_REQ*DATA_W  operand B, same packing
resp_valid_o  out  N_REQ  one-hot result pulse
resp_res_o  out  DATA_W  result, broadcast to all requesters
mul_start_o  out  1  multiplier start
mul_op_a_o  out  DATA_W  multiplier operand A
mul_op_b_o  out  DATA_W  multiplier operand B
mul_done_i  in  1  multiplier done
mul_res_i  in  DATA_W  multiplier result
busy_o  out  1  any operation issued or in flight
error_o  out  1  sticky latency-mismatch flag

Behaviour:
- Reset values: req_ready_o=0, resp_valid_o=0, resp_res_o=0, mul_start_o=0, mul_op_a_o=0, mul_op_b_o=0, busy_o=0, error_o=0, RR pointer=0, tag pipe cleared.
- Grant is combinational.
  - Scan req_valid_i starting at the pointer index, wrapping modulo N_REQ.
  - The first valid index gets req_ready_o[k]=1, and only if en_i=1.
  - At most one bit of req_ready_o is set.
- Handshake: a request is accepted when req_valid_i[k] & req_ready_o[k]. Requesters hold valid and operands stable until accepted.
- On accept at cycle t:
  - The pointer becomes (k+1) mod N_REQ.
  - The issue register loads the operands, and mul_start_o=1 at t+1 (a single-cycle pulse per accept).
  - Back-to-back accepts produce continuous mul_start_o. Throughput is 1 op/cycle.
- Tag pipe: MUL_LAT stages of {valid, index} entered with the issue register. The head stage aligns with mul_done_i.
- At t+1+MUL_LAT, mul_done_i is expected.
  - On the next cycle (t+2+MUL_LAT), resp_valid_o[index]=1 for one cycle and resp_res_o=mul_res_i (registered).
  - With defaults, end-to-end latency is 6 cycles from accept.
- resp_res_o holds its last value while resp_valid_o=0.
- Responses have no backpressure. Requesters must sink results in the pulse cycle.
- Ordering: in-order per requester and globally.
- Latency check, at the cycle the tag head is compared with mul_done_i:
  - Head valid & !mul_done_i: no response, error_o set.
  - !head valid & mul_done_i: result discarded, error_o set.
  - error_o is cleared only by reset.
- Uniform latency is required: the multiplier must be configured so that special-case operands take the same MUL_LAT.
- en_i=0: no new grants. In-flight operations complete normally and the pointer holds.
- busy_o = issue register valid | any tag stage valid | resp_valid_o pending.
- N_REQ=1: the pointer is constant 0, and the grant is req_valid_i & en_i.
- Reset mid-operation: all in-flight operations are dropped. No resp_valid_o is asserted for them after reset, and the pointer returns to 0.
- The multiplier's reset is driven from the same rst_i, which keeps it aligned.

Test Plan:
- Single op: requester 2 sends A=0x40000000, B=0x40400000 at t -> mul_start_o at t+1; resp_valid_o=4'b0100 with resp_res_o=0x40C00000 at t+6; busy_o low afterwards.
- Contention: requesters 0, 1 and 3 all valid at t with distinct operands (1.5*1.5, 2*3, 1*1) -> grants at t, t+1, t+2 in order 0, 1, 3; responses 0x40100000, 0x40C00000, 0x3F800000 at t+6, t+7, t+8 to the matching one-hot bits.
- Fairness: requesters 0 and 2 continuously valid for 8 cycles -> grants alternate 0, 2, 0, 2…; each requester gets exactly 4; mul_start_o stays high for 8 consecutive cycles.
- Enable gating: en_i=0 with all requesters valid -> req_ready_o=0 and no mul_start_o; ops already in flight still respond; raising en_i resumes from the held pointer.
- Reset mid-flight: accept 3 ops, assert rst_i at t+3 -> no resp_valid_o afterwards; all outputs at reset values; the next op after reset is granted to the lowest valid index.
- Latency mismatch: a bench multiplier model returns done at MUL_LAT-1 -> error_o=1 and stays set; result discarded; error_o cleared only by rst_i.
